// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encodings and defaults for the pulse stretcher
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } ps_state_t;

  localparam int unsigned DEFAULT_HIGH_LEN = 8;
  localparam int unsigned DEFAULT_GAP_LEN  = 4;
  localparam int unsigned PS_CNT_W         = 16;

endpackage

// File: rtl/pulse_stretcher_sat_updown_counter.sv
// rtl/pulse_stretcher_sat_updown_counter.sv - saturating up/down event counter
module sat_updown_counter #(
  parameter int unsigned W = 4
) (
  input  logic         CLOCK,
  input  logic         Reset,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_ovf
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] r_count;

  // Simultaneous inc and dec cancel; increments stop at full scale, decrements at zero.
  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != MAX_COUNT)) begin
      r_count <= r_count + W'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_ovf   = i_inc && !i_dec && (r_count == MAX_COUNT);

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches event strobes into fixed-width pulses, queueing overlaps
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned HIGH_LEN = DEFAULT_HIGH_LEN,
  parameter int unsigned GAP_LEN  = DEFAULT_GAP_LEN,
  parameter int unsigned PEND_W   = 4
) (
  input  logic              CLOCK,
  input  logic              Reset,
  input  logic              InputPulse,
  output logic              Stretched,
  output logic              Busy,
  output logic [PEND_W-1:0] Pending,
  output logic              Overflow
);

  localparam logic [PS_CNT_W-1:0] HIGH_LOAD = PS_CNT_W'(HIGH_LEN - 1);
  localparam logic [PS_CNT_W-1:0] GAP_LOAD  =
    (GAP_LEN == 0) ? '0 : PS_CNT_W'(GAP_LEN - 1);
  localparam bit NO_GAP = (GAP_LEN == 0);

  ps_state_t             r_state;
  ps_state_t             w_state_next;
  logic [PS_CNT_W-1:0]   r_count;
  logic [PS_CNT_W-1:0]   w_count_next;
  logic                  r_stretched;
  logic                  r_busy;
  logic                  r_overflow;
  logic [PEND_W-1:0]     w_pending;
  logic                  w_decide;
  logic                  w_start;
  logic                  w_take_input;
  logic                  w_take_pend;
  logic                  w_inc;
  logic                  w_ovf;

  // Cycles on which a new pulse may begin: idle, last gap cycle, or last high cycle when there is no gap.
  assign w_decide = (r_state == ST_IDLE) ||
                    ((r_state == ST_GAP) && (r_count == '0)) ||
                    (NO_GAP && (r_state == ST_HIGH) && (r_count == '0));

  assign w_start      = w_decide && (InputPulse || (w_pending != '0));
  assign w_take_input = w_start && InputPulse;
  assign w_take_pend  = w_start && !InputPulse;
  assign w_inc        = InputPulse && !w_take_input;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_HIGH;
          w_count_next = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (r_count != '0) begin
          w_count_next = r_count - PS_CNT_W'(1);
        end else if (!NO_GAP) begin
          w_state_next = ST_GAP;
          w_count_next = GAP_LOAD;
        end else if (w_start) begin
          w_state_next = ST_HIGH;
          w_count_next = HIGH_LOAD;
        end else begin
          w_state_next = ST_IDLE;
          w_count_next = '0;
        end
      end
      ST_GAP: begin
        if (r_count != '0) begin
          w_count_next = r_count - PS_CNT_W'(1);
        end else if (w_start) begin
          w_state_next = ST_HIGH;
          w_count_next = HIGH_LOAD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_stretched <= 1'b0;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_stretched <= (w_state_next == ST_HIGH);
      r_busy      <= (w_state_next != ST_IDLE);
      r_overflow  <= r_overflow || w_ovf;
    end
  end

  sat_updown_counter #(
    .W (PEND_W)
  ) u_pending (
    .CLOCK   (CLOCK),
    .Reset   (Reset),
    .i_inc   (w_inc),
    .i_dec   (w_take_pend),
    .o_count (w_pending),
    .o_ovf   (w_ovf)
  );

  assign Stretched = r_stretched;
  assign Busy      = r_busy;
  assign Pending   = w_pending;
  assign Overflow  = r_overflow;

endmodule
